// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks producer dst/latency in E..last stage, drives the
// combinational D-stage stall and per-stage, per-operand bypass selects (zero latency).
module hazard_scoreboard #(
   parameter int NPIPE = 3,
   parameter int NSRC  = 2,
   parameter int TW    = 2,
   parameter int SELW  = 2
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [NSRC*5-1:0]          d_src,
   input  logic [NSRC*TW-1:0]         d_tuse,
   input  logic [4:0]                 d_dst,
   input  logic [TW-1:0]              d_tnew,
   input  logic                       d_md_use,
   input  logic                       md_busy,
   input  logic                       md_start,
   input  logic                       freeze,
   input  logic                       kill_m,
   input  logic                       wb_ovr_vld,
   input  logic [4:0]                 wb_ovr_dst,
   output logic                       stall,
   output logic [NPIPE*NSRC*SELW-1:0] fwd_sel
);

   // Sources are only kept where a later stage can still consume them.
   logic [4:0]        r_dst  [1:NPIPE];
   logic [TW-1:0]     r_tnew [1:NPIPE];
   logic [NSRC*5-1:0] r_src  [1:NPIPE-1];

   logic [4:0]        w_edst [1:NPIPE];
   logic [TW-1:0]     w_tdec [1:NPIPE-1];
   logic [NSRC*5-1:0] w_csrc [0:NPIPE-1];
   logic              w_haz;

   always_comb begin
      for (int k = 1; k <= NPIPE; k++) begin
         w_edst[k] = r_dst[k];
      end
      if (wb_ovr_vld) begin
         w_edst[NPIPE] = wb_ovr_dst;
      end
      for (int k = 1; k < NPIPE; k++) begin
         w_tdec[k] = (r_tnew[k] == '0) ? '0 : r_tnew[k] - TW'(1);
      end
      w_csrc[0] = d_src;
      for (int s = 1; s < NPIPE; s++) begin
         w_csrc[s] = r_src[s];
      end
   end

   // Scanning oldest to youngest lets the nearest producer overwrite older matches.
   always_comb begin
      logic [4:0]      w_reg;
      logic            w_hit;
      logic [SELW-1:0] w_k;
      logic [TW-1:0]   w_t;
      w_haz   = 1'b0;
      fwd_sel = '0;
      w_reg   = '0;
      w_hit   = 1'b0;
      w_k     = '0;
      w_t     = '0;
      for (int s = 0; s < NPIPE; s++) begin
         for (int i = 0; i < NSRC; i++) begin
            w_reg = w_csrc[s][5*i +: 5];
            w_hit = 1'b0;
            w_k   = '0;
            w_t   = '0;
            for (int k = NPIPE; k > s; k--) begin
               if (w_reg != 5'd0 && w_edst[k] == w_reg) begin
                  w_hit = 1'b1;
                  w_k   = SELW'(k);
                  w_t   = r_tnew[k];
               end
            end
            if (w_hit && w_t == '0) begin
               fwd_sel[(s*NSRC+i)*SELW +: SELW] = w_k;
            end
            if (s == 0 && w_hit && w_t > d_tuse[TW*i +: TW]) begin
               w_haz = 1'b1;
            end
         end
      end
   end

   assign stall = w_haz | (d_md_use & (md_busy | md_start));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int k = 1; k <= NPIPE; k++) begin
            r_dst[k]  <= '0;
            r_tnew[k] <= '0;
         end
         for (int k = 1; k < NPIPE; k++) begin
            r_src[k] <= '0;
         end
      end else if (!freeze) begin
         r_dst[1]  <= stall ? 5'd0 : d_dst;
         r_tnew[1] <= stall ? '0 : d_tnew;
         r_src[1]  <= stall ? '0 : d_src;
         // Stage 2 is M: a kill turns the incoming entry into a bubble.
         for (int k = 2; k <= NPIPE; k++) begin
            r_dst[k]  <= (k == 2 && kill_m) ? 5'd0 : r_dst[k-1];
            r_tnew[k] <= (k == 2 && kill_m) ? '0 : w_tdec[k-1];
         end
         for (int k = 2; k < NPIPE; k++) begin
            r_src[k] <= (k == 2 && kill_m) ? '0 : r_src[k-1];
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table for the pipeline scenarios,
// then random traffic checked against a queue-of-entries reference model.
module tb_hazard_scoreboard;

   localparam logic [6:0] C_RST  = 7'h40;
   localparam logic [6:0] C_FRZ  = 7'h20;
   localparam logic [6:0] C_KILL = 7'h10;
   localparam logic [6:0] C_OVR  = 7'h08;
   localparam logic [6:0] C_MDU  = 7'h04;
   localparam logic [6:0] C_MDB  = 7'h02;
   localparam logic [6:0] C_MDS  = 7'h01;
   localparam int         NVEC   = 28;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  d_src;
   logic [3:0]  d_tuse;
   logic [4:0]  d_dst;
   logic [1:0]  d_tnew;
   logic        d_md_use, md_busy, md_start, freeze, kill_m, wb_ovr_vld;
   logic [4:0]  wb_ovr_dst;
   logic        stall;
   logic [11:0] fwd_sel;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   hazard_scoreboard #(.NPIPE(3), .NSRC(2), .TW(2), .SELW(2)) dut (
      .Clk(Clk), .Reset(Reset), .d_src(d_src), .d_tuse(d_tuse), .d_dst(d_dst),
      .d_tnew(d_tnew), .d_md_use(d_md_use), .md_busy(md_busy), .md_start(md_start),
      .freeze(freeze), .kill_m(kill_m), .wb_ovr_vld(wb_ovr_vld), .wb_ovr_dst(wb_ovr_dst),
      .stall(stall), .fwd_sel(fwd_sel)
   );

   typedef struct packed {
      logic [4:0] dst;
      logic [1:0] tnew;
      logic [4:0] src0;
      logic [4:0] src1;
   } ent_t;

   typedef struct {
      logic [6:0]  ctl;
      logic [4:0]  ovd;
      logic [4:0]  src0, src1;
      logic [1:0]  tu0, tu1;
      logic [4:0]  dst;
      logic [1:0]  tnew;
      logic        est;
      logic [11:0] efwd;
   } vec_t;

   ent_t pipe [1:3];
   vec_t tab  [0:NVEC-1];

   function automatic vec_t mk(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] t0,
                               input logic [1:0] t1, input logic [4:0] dd, input logic [1:0] dt,
                               input logic [6:0] ctl, input logic [4:0] ovd, input logic est,
                               input logic [11:0] efwd);
      vec_t v;
      v.ctl = ctl; v.ovd = ovd; v.src0 = s0; v.src1 = s1; v.tu0 = t0; v.tu1 = t1;
      v.dst = dd; v.tnew = dt; v.est = est; v.efwd = efwd;
      return v;
   endfunction

   task automatic drive(input logic [6:0] ctl, input logic [4:0] ovd, input logic [4:0] s0,
                        input logic [4:0] s1, input logic [1:0] t0, input logic [1:0] t1,
                        input logic [4:0] dd, input logic [1:0] dt);
      Reset = ctl[6]; freeze = ctl[5]; kill_m = ctl[4]; wb_ovr_vld = ctl[3];
      d_md_use = ctl[2]; md_busy = ctl[1]; md_start = ctl[0];
      wb_ovr_dst = ovd; d_src = {s1, s0}; d_tuse = {t1, t0}; d_dst = dd; d_tnew = dt;
   endtask

   // Reference: for each consumer operand, walk producers youngest first and stop at the first owner.
   function automatic void model_eval(output logic est, output logic [11:0] efwd);
      logic [4:0] r, own;
      int         tn;
      est  = d_md_use & (md_busy | md_start);
      efwd = '0;
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 2; i++) begin
            if (s == 0) r = d_src[5*i +: 5];
            else        r = (i == 0) ? pipe[s].src0 : pipe[s].src1;
            if (r == 5'd0) continue;
            for (int k = s + 1; k <= 3; k++) begin
               own = (k == 3 && wb_ovr_vld) ? wb_ovr_dst : pipe[k].dst;
               if (own == r) begin
                  tn = int'(pipe[k].tnew);
                  if (tn == 0) efwd[(s*2+i)*2 +: 2] = 2'(k);
                  if (s == 0 && tn > int'(d_tuse[2*i +: 2])) est = 1'b1;
                  break;
               end
            end
         end
      end
   endfunction

   task automatic model_clock(input logic est);
      ent_t e;
      if (Reset) begin
         for (int k = 1; k <= 3; k++) pipe[k] = '0;
      end else if (!freeze) begin
         for (int k = 3; k >= 2; k--) begin
            pipe[k] = pipe[k-1];
            if (pipe[k].tnew != 2'd0) pipe[k].tnew = pipe[k].tnew - 2'd1;
         end
         e.dst = d_dst; e.tnew = d_tnew; e.src0 = d_src[4:0]; e.src1 = d_src[9:5];
         if (est) pipe[1] = '0;
         else     pipe[1] = e;
         if (kill_m) pipe[2] = '0;
      end
   endtask

   task automatic check(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   initial begin
      logic        ms;
      logic [11:0] mf;
      logic [6:0]  c;

      tab[0]  = mk(0, 0, 0, 0, 0, 0, 7'h00, 0, 0, 12'h000);            // idle after reset
      tab[1]  = mk(0, 0, 0, 0, 0, 0, C_MDU | C_MDB, 0, 1, 12'h000);
      tab[2]  = mk(0, 0, 0, 0, 0, 0, C_MDU | C_MDS, 0, 1, 12'h000);
      tab[3]  = mk(0, 0, 0, 0, 0, 0, C_OVR, 0, 0, 12'h000);            // r0 never forwards
      tab[4]  = mk(0, 0, 0, 0, 0, 0, C_MDB | C_MDS, 0, 0, 12'h000);
      tab[5]  = mk(29, 0, 1, 0, 8, 2, 7'h00, 0, 0, 12'h000);           // lw $8
      tab[6]  = mk(8, 8, 1, 1, 9, 1, 7'h00, 0, 1, 12'h000);            // add $9,$8,$8
      tab[7]  = mk(8, 8, 1, 1, 9, 1, 7'h00, 0, 0, 12'h000);
      tab[8]  = mk(0, 0, 0, 0, 0, 0, 7'h00, 0, 0, 12'h0F0);            // load result at W output
      tab[9]  = mk(0, 0, 0, 0, 7, 3, C_RST | C_FRZ | C_KILL, 0, 0, 12'h000);
      tab[10] = mk(1, 2, 1, 1, 5, 1, 7'h00, 0, 0, 12'h000);            // addu $5
      tab[11] = mk(5, 0, 0, 0, 0, 0, 7'h00, 0, 1, 12'h000);            // beq $5
      tab[12] = mk(5, 0, 0, 0, 0, 0, 7'h00, 0, 0, 12'h002);
      tab[13] = mk(0, 0, 0, 0, 31, 0, 7'h00, 0, 0, 12'h030);           // jal
      tab[14] = mk(31, 0, 0, 0, 0, 0, 7'h00, 0, 0, 12'h001);           // jr $31
      tab[15] = mk(0, 0, 0, 0, 4, 0, 7'h00, 0, 0, 12'h020);
      tab[16] = mk(0, 0, 0, 0, 4, 0, 7'h00, 0, 0, 12'h300);
      tab[17] = mk(4, 31, 1, 1, 0, 0, 7'h00, 0, 0, 12'h001);
      tab[18] = mk(0, 0, 0, 0, 0, 0, C_FRZ, 0, 0, 12'h020);            // nearest $4 is M
      tab[19] = mk(0, 0, 0, 0, 0, 0, C_FRZ | C_OVR, 31, 0, 12'h0E0);
      tab[20] = mk(29, 0, 1, 0, 10, 2, 7'h00, 0, 0, 12'h020);          // lw $10
      tab[21] = mk(10, 0, 1, 0, 11, 1, C_FRZ, 0, 1, 12'h300);
      tab[22] = mk(10, 0, 1, 0, 11, 1, C_FRZ, 0, 1, 12'h300);
      tab[23] = mk(10, 0, 1, 0, 11, 1, C_FRZ, 0, 1, 12'h300);
      tab[24] = mk(10, 0, 2, 0, 11, 1, 7'h00, 0, 0, 12'h300);
      tab[25] = mk(11, 10, 0, 0, 12, 1, C_KILL, 0, 1, 12'h000);        // stall + kill together
      tab[26] = mk(11, 10, 0, 0, 12, 1, 7'h00, 0, 0, 12'h00C);
      tab[27] = mk(0, 0, 0, 0, 0, 0, 7'h00, 0, 0, 12'h000);

      for (int k = 1; k <= 3; k++) pipe[k] = '0;
      drive(C_RST, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge Clk);
      model_clock(1'b0);

      for (int n = 0; n < NVEC; n++) begin
         @(negedge Clk);
         drive(tab[n].ctl, tab[n].ovd, tab[n].src0, tab[n].src1, tab[n].tu0, tab[n].tu1,
               tab[n].dst, tab[n].tnew);
         #1;
         model_eval(ms, mf);
         check("vec_stall", n, {11'b0, stall}, {11'b0, tab[n].est});
         check("vec_fwd", n, fwd_sel, tab[n].efwd);
         @(posedge Clk);
         model_clock(ms);
      end

      for (int n = 0; n < 2000; n++) begin
         @(negedge Clk);
         c = '0;
         if ($urandom_range(0, 99) == 0) c = c | C_RST;
         if ($urandom_range(0, 9)  == 0) c = c | C_FRZ;
         if ($urandom_range(0, 7)  == 0) c = c | C_KILL;
         if ($urandom_range(0, 5)  == 0) c = c | C_OVR;
         if ($urandom_range(0, 4)  == 0) c = c | C_MDU;
         if ($urandom_range(0, 2)  == 0) c = c | C_MDB;
         if ($urandom_range(0, 2)  == 0) c = c | C_MDS;
         drive(c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
         #1;
         model_eval(ms, mf);
         check("rnd_stall", n, {11'b0, stall}, {11'b0, ms});
         check("rnd_fwd", n, fwd_sel, mf);
         @(posedge Clk);
         model_clock(ms);
      end

      @(negedge Clk);
      drive(7'h00, 0, 0, 0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
